// File: rtl/uart_receiver_if.sv
// Bundles the UART receiver's serial input, parity selection and received-word outputs.
// The bench or a bus adapter takes the master side; the receiver takes the slave side.
interface uart_receiver_if #(
    parameter int Data_length = 8
);
    logic                   serialdata_in;
    logic                   parity_type;
    logic [Data_length-1:0] dataout;
    logic                   rx_done;
    logic                   parity_err;
    logic                   frame_err;
    logic                   rx_busy;

    modport master (
        output serialdata_in, parity_type,
        input  dataout, rx_done, parity_err, frame_err, rx_busy
    );

    modport slave (
        input  serialdata_in, parity_type,
        output dataout, rx_done, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start bit, Data_length data bits (LSB first), optional parity, one stop bit.
// Each completed frame gives a one-cycle rx_done together with parity and framing flags.
module uart_receiver #(
    parameter int Data_length  = 8,
    parameter bit parity_en    = 1'b0,
    parameter int clks_per_bit = 20
) (
    input  logic           clk1,
    input  logic           rst,
    uart_receiver_if.slave bus
);
    localparam int HALF = clks_per_bit / 2;
    localparam int CW   = $clog2(clks_per_bit);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic                   sync1, rx_s, rx_prev;
    logic [CW-1:0]          cnt;
    logic [3:0]             bitcnt;
    logic [Data_length-1:0] shreg;
    logic                   par_bit;
    logic                   fall, half_end, cnt_end, last_bit;

    assign fall     = ~rx_s & rx_prev;
    assign half_end = (cnt == CW'(HALF - 1));
    assign cnt_end  = (cnt == CW'(clks_per_bit - 1));
    assign last_bit = (bitcnt == 4'(Data_length - 1));
    assign bus.rx_busy = (state != IDLE);

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall)     state_nxt = START;
            START:   if (half_end) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (cnt_end && last_bit) state_nxt = parity_en ? PARITY : STOP;
            PARITY:  if (cnt_end)  state_nxt = STOP;
            STOP:    if (cnt_end)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Synchroniser and edge history reset high so a line idling high never looks like a start edge.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= bus.serialdata_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            bitcnt         <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            bus.dataout    <= '0;
            bus.rx_done    <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.rx_done <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                START: begin
                    cnt <= half_end ? '0 : cnt + 1'b1;
                    if (half_end) bitcnt <= '0;
                end
                DATA: begin
                    cnt <= cnt_end ? '0 : cnt + 1'b1;
                    if (cnt_end) begin
                        for (int i = 0; i < Data_length; i++)
                            if (bitcnt == 4'(i)) shreg[i] <= rx_s;
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                PARITY: begin
                    cnt <= cnt_end ? '0 : cnt + 1'b1;
                    if (cnt_end) par_bit <= rx_s;
                end
                STOP: begin
                    cnt <= cnt_end ? '0 : cnt + 1'b1;
                    // Leaving STOP mid stop bit lets a start edge right after it be caught.
                    if (cnt_end) begin
                        bus.dataout    <= shreg;
                        bus.frame_err  <= ~rx_s;
                        bus.parity_err <= parity_en & (par_bit != (^shreg ^ bus.parity_type));
                        bus.rx_done    <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one DUT without parity, one with parity, on a shared clock and reset.
module tb_uart_receiver;
    localparam int CPB = 20;
    localparam int DW  = 8;

    logic clk1 = 1'b0;
    logic rst  = 1'b0;
    int   cyc  = 0;
    int   pass = 0;
    int   total = 0;
    int   done_n0 = 0;
    int   done_n1 = 0;
    int   done_t0[$];
    logic [DW-1:0] done_d0[$];

    uart_receiver_if #(.Data_length(DW)) bus0 ();
    uart_receiver_if #(.Data_length(DW)) bus1 ();

    uart_receiver #(.Data_length(DW), .parity_en(1'b0), .clks_per_bit(CPB)) u0 (
        .clk1(clk1), .rst(rst), .bus(bus0)
    );
    uart_receiver #(.Data_length(DW), .parity_en(1'b1), .clks_per_bit(CPB)) u1 (
        .clk1(clk1), .rst(rst), .bus(bus1)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (bus0.rx_done) begin
            done_n0 = done_n0 + 1;
            done_t0.push_back(cyc);
            done_d0.push_back(bus0.dataout);
        end
        if (bus1.rx_done) done_n1 = done_n1 + 1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) bus0.serialdata_in = v;
        else            bus1.serialdata_in = v;
    endtask

    // Leaves the line at the stop-bit level; fall_at is the cycle count when the pin fell.
    task automatic send_frame(input int which, input logic [DW-1:0] d, input logic use_par,
                              input logic pb, input logic sb, output int fall_at);
        set_line(which, 1'b0);
        fall_at = cyc;
        wait_n(CPB);
        for (int i = 0; i < DW; i++) begin
            set_line(which, d[i]);
            wait_n(CPB);
        end
        if (use_par) begin
            set_line(which, pb);
            wait_n(CPB);
        end
        set_line(which, sb);
        wait_n(CPB);
    endtask

    task automatic test_reset();
        wait_n(3);
        total++; if (bus0.dataout !== 8'h00) $display("FAIL reset_dataout got %h exp 00", bus0.dataout); else pass++;
        total++; if (bus0.rx_done !== 1'b0) $display("FAIL reset_rx_done got %b exp 0", bus0.rx_done); else pass++;
        total++; if (bus0.rx_busy !== 1'b0) $display("FAIL reset_rx_busy got %b exp 0", bus0.rx_busy); else pass++;
        total++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {bus0.parity_err, bus0.frame_err}); else pass++;
        rst = 1'b1;
        wait_n(10);
    endtask

    task automatic test_basic();
        int f, n;
        n = done_n0;
        done_t0.delete(); done_d0.delete();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, f);
        wait_n(5);
        total++; if (done_n0 - n !== 1) $display("FAIL basic_done_count got %0d exp 1", done_n0 - n); else pass++;
        total++; if (done_t0.size() < 1 || done_t0[0] !== f + 193) $display("FAIL basic_done_time got %0d exp %0d", done_t0.size() ? done_t0[0] : -1, f + 193); else pass++;
        total++; if (bus0.dataout !== 8'hA5) $display("FAIL basic_dataout got %h exp a5", bus0.dataout); else pass++;
        total++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) $display("FAIL basic_flags got %b exp 00", {bus0.parity_err, bus0.frame_err}); else pass++;
        total++; if (bus0.rx_busy !== 1'b0) $display("FAIL basic_busy got %b exp 0", bus0.rx_busy); else pass++;
    endtask

    task automatic test_parity();
        int f, n;
        n = done_n1;
        bus1.parity_type = 1'b0;
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, f);
        wait_n(5);
        total++; if (bus1.parity_err !== 1'b0) $display("FAIL par_even_ok got %b exp 0", bus1.parity_err); else pass++;
        total++; if (bus1.dataout !== 8'h3C) $display("FAIL par_even_ok_data got %h exp 3c", bus1.dataout); else pass++;
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, f);
        wait_n(5);
        total++; if (bus1.parity_err !== 1'b1) $display("FAIL par_even_bad got %b exp 1", bus1.parity_err); else pass++;
        total++; if (bus1.dataout !== 8'h3C) $display("FAIL par_even_bad_data got %h exp 3c", bus1.dataout); else pass++;
        bus1.parity_type = 1'b1;
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, f);
        wait_n(5);
        total++; if (bus1.parity_err !== 1'b0) $display("FAIL par_odd_ok got %b exp 0", bus1.parity_err); else pass++;
        total++; if (done_n1 - n !== 3) $display("FAIL par_done_count got %0d exp 3", done_n1 - n); else pass++;
        total++; if (bus1.frame_err !== 1'b0) $display("FAIL par_frame_err got %b exp 0", bus1.frame_err); else pass++;
    endtask

    task automatic test_glitch();
        int c, n;
        n = done_n0;
        set_line(0, 1'b0);
        c = cyc;
        wait_n(5);
        total++; if (bus0.rx_busy !== 1'b1) $display("FAIL glitch_busy_high got %b exp 1", bus0.rx_busy); else pass++;
        set_line(0, 1'b1);
        wait_n(c + 12 - cyc);
        total++; if (bus0.rx_busy !== 1'b1) $display("FAIL glitch_busy_t9 got %b exp 1", bus0.rx_busy); else pass++;
        wait_n(1);
        total++; if (bus0.rx_busy !== 1'b0) $display("FAIL glitch_busy_t10 got %b exp 0", bus0.rx_busy); else pass++;
        wait_n(200);
        total++; if (done_n0 - n !== 0) $display("FAIL glitch_no_done got %0d exp 0", done_n0 - n); else pass++;
        total++; if (bus0.dataout !== 8'hA5) $display("FAIL glitch_data_held got %h exp a5", bus0.dataout); else pass++;
    endtask

    task automatic test_frame_err();
        int f, n;
        n = done_n0;
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, f);
        wait_n(5);
        total++; if (done_n0 - n !== 1) $display("FAIL ferr_done_count got %0d exp 1", done_n0 - n); else pass++;
        total++; if (bus0.dataout !== 8'h81) $display("FAIL ferr_dataout got %h exp 81", bus0.dataout); else pass++;
        total++; if (bus0.frame_err !== 1'b1) $display("FAIL ferr_flag got %b exp 1", bus0.frame_err); else pass++;
        wait_n(300);
        total++; if (done_n0 - n !== 1) $display("FAIL ferr_held_low got %0d exp 1", done_n0 - n); else pass++;
        total++; if (bus0.rx_busy !== 1'b0) $display("FAIL ferr_held_busy got %b exp 0", bus0.rx_busy); else pass++;
        set_line(0, 1'b1);
        wait_n(CPB);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, f);
        wait_n(5);
        total++; if (done_n0 - n !== 2) $display("FAIL ferr_recover_count got %0d exp 2", done_n0 - n); else pass++;
        total++; if (bus0.frame_err !== 1'b0 || bus0.dataout !== 8'h5A) $display("FAIL ferr_recover got %b/%h exp 0/5a", bus0.frame_err, bus0.dataout); else pass++;
    endtask

    task automatic test_back_to_back();
        int f, g;
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
        done_t0.delete(); done_d0.delete();
        send_frame(0, exp_d[0], 1'b0, 1'b0, 1'b1, f);
        send_frame(0, exp_d[1], 1'b0, 1'b0, 1'b1, g);
        send_frame(0, exp_d[2], 1'b0, 1'b0, 1'b1, g);
        wait_n(5);
        total++; if (done_t0.size() !== 3) $display("FAIL b2b_count got %0d exp 3", done_t0.size()); else pass++;
        for (int i = 0; i < 3; i++) begin
            if (i < done_t0.size()) begin
                total++; if (done_t0[i] !== f + 193 + 200 * i) $display("FAIL b2b_time%0d got %0d exp %0d", i, done_t0[i], f + 193 + 200 * i); else pass++;
                total++; if (done_d0[i] !== exp_d[i]) $display("FAIL b2b_data%0d got %h exp %h", i, done_d0[i], exp_d[i]); else pass++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int f, n;
        n = done_n0;
        set_line(0, 1'b0);
        wait_n(CPB);
        for (int i = 0; i < 4; i++) begin
            set_line(0, i[0]);
            wait_n(CPB);
        end
        set_line(0, 1'b1);
        wait_n(CPB / 2);
        rst = 1'b0;
        #1;
        total++; if (bus0.dataout !== 8'h00) $display("FAIL rstmid_dataout got %h exp 00", bus0.dataout); else pass++;
        total++; if (bus0.rx_busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", bus0.rx_busy); else pass++;
        wait_n(2);
        rst = 1'b1;
        wait_n(40);
        total++; if (done_n0 - n !== 0) $display("FAIL rstmid_no_done got %0d exp 0", done_n0 - n); else pass++;
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, f);
        wait_n(5);
        total++; if (done_n0 - n !== 1) $display("FAIL rstmid_next_count got %0d exp 1", done_n0 - n); else pass++;
        total++; if (bus0.dataout !== 8'h12) $display("FAIL rstmid_next_data got %h exp 12", bus0.dataout); else pass++;
    endtask

    initial begin
        bus0.serialdata_in = 1'b1;
        bus0.parity_type   = 1'b0;
        bus1.serialdata_in = 1'b1;
        bus1.parity_type   = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        total++; if (bus0.parity_err !== 1'b0) $display("FAIL nopar_parity_err got %b exp 0", bus0.parity_err); else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver and companion to the UART transmitter in the UART protocol block. Recovers frames of start bit, Data_length data bits (LSB first), optional parity bit and one stop bit from an asynchronous serial line, oversampled on the system clock. It presents each received word with a one-cycle completion strobe plus parity and framing error flags.

## Interface
- Data_length, 8, number of data bits per frame (1..15).
- parity_en, 0, 1 = parity bit present after the data bits; 0 = no parity bit.
- clks_per_bit, 20, clk1 cycles per bit period (even, ≥ 4); HALF = clks_per_bit/2.
- clk1  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- serialdata_in  input  1  asynchronous serial line; idle high.
- parity_type  input  1  0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data). Must be stable for the whole frame.
- dataout  output  Data_length  last received word, bit 0 = first data bit received.
- rx_done  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch in the last completed frame (always 0 when parity_en = 0).
- frame_err  output  1  stop bit sampled low in the last completed frame.
- rx_busy  output  1  high in every state except IDLE.

## Operation
- Input synchroniser: two flops on serialdata_in, both reset to 1; the second flop output is rx_s. One more flop, rx_prev, also resets to 1.
- Counters: cnt, a bit-period counter wide enough for clks_per_bit-1. bitcnt, 4 bits. Shift register, Data_length bits.
- IDLE: rx_busy = 0. On rx_s = 0 and rx_prev = 1 (falling edge): cnt <= 0, state <= START. A line held low never retriggers, because an edge is required.
- START: cnt increments. At cnt = HALF-1:
  - rx_s = 0: cnt <= 0, bitcnt <= 0, state <= DATA.
  - rx_s = 1: the edge was a glitch; state <= IDLE with no outputs changed.
- DATA: cnt increments. At cnt = clks_per_bit-1:
  - sample rx_s into shift register bit bitcnt; cnt <= 0; bitcnt++.
  - After the Data_length-th sample: state <= PARITY if parity_en, else STOP.
- PARITY: at cnt = clks_per_bit-1, sample rx_s into a parity flop; cnt <= 0; state <= STOP.
- STOP: at cnt = clks_per_bit-1, on the same edge:
  - dataout <= shift register.
  - frame_err <= ~rx_s.
  - parity_err <= parity_en & (sampled parity ≠ expected parity), where expected = ^data XOR parity_type.
  - rx_done <= 1.
  - state <= IDLE.
- Errors do not suppress rx_done. Data is always delivered, with the flags set alongside it.
- dataout, parity_err and frame_err hold their values until the next completed frame.

## Timing
- Reset values: dataout = 0, rx_done = 0, parity_err = 0, frame_err = 0, rx_busy = 0, state = IDLE, all counters 0.
- t0 is the clk1 edge on which IDLE detects the falling edge. rx_s lags the pin by 2 cycles, so t0 is 3 edges after the pin falls.
- Start bit is checked at t0+HALF.
- Data bit k (k = 0..Data_length-1) is sampled at t0+HALF+(k+1)·clks_per_bit.
- Parity bit is sampled at t0+HALF+(Data_length+1)·clks_per_bit.
- Stop bit is sampled at E = t0+HALF+(Data_length+parity_en+1)·clks_per_bit. rx_done is high for exactly the cycle after edge E.
- Defaults: E = t0+190; rx_done spans the interval (E, E+1].
- Back-to-back frames: IDLE is re-entered HALF cycles before the end of the stop bit, so a start edge arriving immediately after the stop bit is caught.
- Reset asserted mid-frame: everything returns to reset values at once; no rx_done is issued for the partial frame.
- After reset releases, the first falling edge is detected only after rx_s has been seen high.

## Test plan
- Defaults, frame 0xA5 sent at 20 clocks/bit -> dataout = 0xA5, rx_done high for exactly 1 cycle at t0+191, both error flags 0, rx_busy low afterwards.
- parity_en = 1, parity_type = 0, 0x3C with parity bit 0 -> parity_err = 0. Same frame with parity bit 1 -> parity_err = 1, dataout = 0x3C. Repeat with parity_type = 1 and parity bit 1 -> parity_err = 0.
- Line low for 5 cycles then high -> START aborts at t0+10, rx_busy pulses high then low, no rx_done, outputs unchanged.
- 0x81 with stop bit driven 0 -> rx_done with dataout = 0x81 and frame_err = 1. Line then held low -> no further rx_done until a high-then-low edge occurs.
- Three back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three rx_done pulses exactly 200 cycles apart, correct data each time.
- rst pulsed low during bit 4 of a frame -> outputs return to 0 immediately, no rx_done. A following clean frame 0x12 is received correctly.
